// File: rtl/hsl_color_mask.sv
// rtl/hsl_color_mask.sv - HSL window colour mask with per-frame match count and optional bbox
// Bounding-box tracking is built only when HSL_MASK_BBOX_EN is defined.
module hsl_color_mask #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           FrameStart,
  input  logic           HSLEn,
  input  logic [7:0]     H,
  input  logic [7:0]     S,
  input  logic [7:0]     L,
  input  logic           cfg_wr,
  input  logic [2:0]     cfg_addr,
  input  logic [7:0]     cfg_data,
  output logic           mask_en,
  output logic           mask,
  output logic           frame_done,
  output logic [19:0]    match_count,
  output logic           bbox_valid,
  output logic [X_W-1:0] xmin,
  output logic [X_W-1:0] xmax,
  output logic [Y_W-1:0] ymin,
  output logic [Y_W-1:0] ymax
);

  localparam logic [X_W-1:0] X_LAST  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(IMG_H - 1);
  localparam logic [19:0]    CNT_MAX = '1;
  localparam logic [7:0]     V_MAX   = 8'd240;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_q, state_d;

  logic [7:0] sh_hlo, sh_hhi, sh_slo, sh_shi, sh_llo, sh_lhi;
  logic       sh_inv;
  logic [7:0] hlo, hhi, slo, shi, llo, lhi;
  logic       inv;

  // Shadow takes writes any time; active follows shadow only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_hlo <= '0;  sh_hhi <= V_MAX;
      sh_slo <= '0;  sh_shi <= V_MAX;
      sh_llo <= '0;  sh_lhi <= V_MAX;
      sh_inv <= 1'b0;
      hlo    <= '0;  hhi    <= V_MAX;
      slo    <= '0;  shi    <= V_MAX;
      llo    <= '0;  lhi    <= V_MAX;
      inv    <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (cfg_addr)
          3'd0:    sh_hlo <= cfg_data;
          3'd1:    sh_hhi <= cfg_data;
          3'd2:    sh_slo <= cfg_data;
          3'd3:    sh_shi <= cfg_data;
          3'd4:    sh_llo <= cfg_data;
          3'd5:    sh_lhi <= cfg_data;
          3'd6:    sh_inv <= cfg_data[0];
          default: ;
        endcase
      end
      if (state_q == IDLE) begin
        hlo <= sh_hlo;  hhi <= sh_hhi;
        slo <= sh_slo;  shi <= sh_shi;
        llo <= sh_llo;  lhi <= sh_lhi;
        inv <= sh_inv;
      end
    end
  end

  logic hue_hit, sat_hit, lit_hit, pix_hit;

  always_comb begin
    if (hlo <= hhi) hue_hit = (H >= hlo) && (H <= hhi);
    else            hue_hit = (H >= hlo) || (H <= hhi);
    sat_hit = (S >= slo) && (S <= shi);
    lit_hit = (L >= llo) && (L <= lhi);
    pix_hit = (hue_hit && sat_hit && lit_hit) ^ inv;
  end

  logic           accept, pix_last;
  logic [X_W-1:0] x_q, cur_x;
  logic [Y_W-1:0] y_q, cur_y;

  // A FrameStart pixel is always (0,0), whatever the counters held.
  always_comb begin
    accept   = HSLEn && (FrameStart || state_q == ACTIVE);
    cur_x    = FrameStart ? '0 : x_q;
    cur_y    = FrameStart ? '0 : y_q;
    pix_last = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
    state_d  = state_q;
    case (state_q)
      IDLE:    if (FrameStart) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      DONE:    state_d = FrameStart ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
    if (pix_last) state_d = DONE;
  end

  logic s1_last, s1_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      mask_en  <= 1'b0;
      mask     <= 1'b0;
      s1_last  <= 1'b0;
      s1_start <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_en  <= accept;
      mask     <= accept && pix_hit;
      s1_last  <= pix_last;
      s1_start <= FrameStart;
      if (accept) begin
        if (cur_x == X_LAST) begin
          x_q <= '0;
          y_q <= pix_last ? '0 : cur_y + Y_W'(1);
        end else begin
          x_q <= cur_x + X_W'(1);
          y_q <= cur_y;
        end
      end else if (FrameStart) begin
        x_q <= '0;
        y_q <= '0;
      end
    end
  end

  logic        hit2;
  logic [19:0] acc_cnt, base_cnt, nxt_cnt;

  // Delayed FrameStart wipes the partial frame ahead of the pixel it came with.
  always_comb begin
    hit2     = mask_en && mask;
    base_cnt = s1_start ? '0 : acc_cnt;
    nxt_cnt  = (hit2 && base_cnt != CNT_MAX) ? base_cnt + 20'd1 : base_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt     <= '0;
      frame_done  <= 1'b0;
      match_count <= '0;
    end else begin
      frame_done <= s1_last;
      if (s1_last) begin
        match_count <= nxt_cnt;
        acc_cnt     <= '0;
      end else begin
        acc_cnt <= nxt_cnt;
      end
    end
  end

`ifdef HSL_MASK_BBOX_EN
  logic [X_W-1:0] s1_x;
  logic [Y_W-1:0] s1_y;
  logic           acc_any, base_any, nxt_any;
  logic [X_W-1:0] acc_xmin, acc_xmax, base_xmin, base_xmax, nxt_xmin, nxt_xmax;
  logic [Y_W-1:0] acc_ymin, acc_ymax, base_ymin, base_ymax, nxt_ymin, nxt_ymax;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x <= '0;
      s1_y <= '0;
    end else begin
      s1_x <= cur_x;
      s1_y <= cur_y;
    end
  end

  always_comb begin
    base_any  = !s1_start && acc_any;
    base_xmin = s1_start ? '0 : acc_xmin;
    base_xmax = s1_start ? '0 : acc_xmax;
    base_ymin = s1_start ? '0 : acc_ymin;
    base_ymax = s1_start ? '0 : acc_ymax;
    nxt_any   = base_any || hit2;
    nxt_xmin  = base_xmin;
    nxt_xmax  = base_xmax;
    nxt_ymin  = base_ymin;
    nxt_ymax  = base_ymax;
    if (hit2 && !base_any) begin
      nxt_xmin = s1_x;  nxt_xmax = s1_x;
      nxt_ymin = s1_y;  nxt_ymax = s1_y;
    end else if (hit2) begin
      if (s1_x < base_xmin) nxt_xmin = s1_x;
      if (s1_x > base_xmax) nxt_xmax = s1_x;
      if (s1_y < base_ymin) nxt_ymin = s1_y;
      if (s1_y > base_ymax) nxt_ymax = s1_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_any    <= 1'b0;
      acc_xmin   <= '0;  acc_xmax <= '0;
      acc_ymin   <= '0;  acc_ymax <= '0;
      bbox_valid <= 1'b0;
      xmin       <= '0;  xmax     <= '0;
      ymin       <= '0;  ymax     <= '0;
    end else if (s1_last) begin
      bbox_valid <= nxt_any;
      xmin       <= nxt_xmin;  xmax <= nxt_xmax;
      ymin       <= nxt_ymin;  ymax <= nxt_ymax;
      acc_any    <= 1'b0;
      acc_xmin   <= '0;  acc_xmax <= '0;
      acc_ymin   <= '0;  acc_ymax <= '0;
    end else begin
      acc_any    <= nxt_any;
      acc_xmin   <= nxt_xmin;  acc_xmax <= nxt_xmax;
      acc_ymin   <= nxt_ymin;  acc_ymax <= nxt_ymax;
    end
  end
`else
  assign bbox_valid = 1'b0;
  assign xmin       = '0;
  assign xmax       = '0;
  assign ymin       = '0;
  assign ymax       = '0;
`endif

endmodule

// File: tb/tb_hsl_color_mask.sv
// tb/tb_hsl_color_mask.sv - randomized self-checking bench for hsl_color_mask on 4x2 frames
// Bbox expectations follow HSL_MASK_BBOX_EN.
`timescale 1ns/1ps
module tb_hsl_color_mask;

  localparam int W    = 4;
  localparam int HT   = 2;
  localparam int NPIX = W * HT;
`ifdef HSL_MASK_BBOX_EN
  localparam bit BBOX = 1'b1;
`else
  localparam bit BBOX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs = 1'b0, en = 1'b0, wr = 1'b0;
  logic [7:0]  h = '0, s = '0, l = '0, cd = '0;
  logic [2:0]  ca = '0;
  logic        mask_en, mask, frame_done, bbox_valid;
  logic [19:0] match_count;
  logic [9:0]  xmin, xmax, ymin, ymax;

  hsl_color_mask #(.IMG_W(W), .IMG_H(HT), .X_W(10), .Y_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .FrameStart(fs), .HSLEn(en),
    .H(h), .S(s), .L(l),
    .cfg_wr(wr), .cfg_addr(ca), .cfg_data(cd),
    .mask_en(mask_en), .mask(mask), .frame_done(frame_done),
    .match_count(match_count), .bbox_valid(bbox_valid),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0, done_cnt = 0, done_edge = 0, last_edge = 0, done_base = 0;
  logic got_mask[$];
  int   sh[8];
  int   ph[NPIX], ps[NPIX], pl[NPIX];
  logic exp_mask[NPIX];
  int   exp_cnt;
  logic exp_any;
  logic [39:0] exp_bb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mask_en) got_mask.push_back(mask);
      if (frame_done) begin
        done_cnt  = done_cnt + 1;
        done_edge = cyc;
      end
    end
  end

  function automatic logic ref_hit(int hv, int sv, int lv);
    logic hue_ok, sat_ok, lit_ok;
    if (sh[0] <= sh[1]) hue_ok = (hv >= sh[0]) && (hv <= sh[1]);
    else                hue_ok = (hv >= sh[0]) || (hv <= sh[1]);
    sat_ok = (sv >= sh[2]) && (sv <= sh[3]);
    lit_ok = (lv >= sh[4]) && (lv <= sh[5]);
    return (hue_ok && sat_ok && lit_ok) ^ ((sh[6] & 1) != 0);
  endfunction

  task automatic compute_expected();
    int x0 = W, x1 = -1, y0 = HT, y1 = -1;
    exp_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      exp_mask[i] = ref_hit(ph[i], ps[i], pl[i]);
      if (exp_mask[i]) begin
        exp_cnt++;
        if (i % W < x0) x0 = i % W;
        if (i % W > x1) x1 = i % W;
        if (i / W < y0) y0 = i / W;
        if (i / W > y1) y1 = i / W;
      end
    end
    exp_any = (BBOX && exp_cnt > 0);
    exp_bb  = exp_any ? {10'(x0), 10'(x1), 10'(y0), 10'(y1)} : 40'd0;
  endtask

  task automatic drive(input bit f, input bit e, input int hv, input int sv, input int lv,
                       input bit w, input int a, input int d);
    fs = f; en = e; h = 8'(hv); s = 8'(sv); l = 8'(lv);
    wr = w; ca = 3'(a); cd = 8'(d);
    @(posedge clk); #1;
    fs = 1'b0; en = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg_write(input int a, input int d);
    drive(0, 0, 0, 0, 0, 1, a, d);
    sh[a] = d;
  endtask

  task automatic cfg_defaults();
    cfg_write(0, 0);  cfg_write(1, 240);
    cfg_write(2, 0);  cfg_write(3, 240);
    cfg_write(4, 0);  cfg_write(5, 240);
    cfg_write(6, 0);
  endtask

  task automatic send_frame(input int gap, input bit fs_sep, input int wr_at, input int wa, input int wd);
    idle(2);
    got_mask.delete();
    done_base = done_cnt;
    if (fs_sep) drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) begin
      int g;
      g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
      idle(g);
      drive(!fs_sep && i == 0, 1, ph[i], ps[i], pl[i], i == wr_at, wa, wd);
      if (i == wr_at) sh[wa] = wd;
    end
    last_edge = cyc;
    for (int k = 0; k < 8 && done_cnt == done_base; k++) idle(1);
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    sh = '{0, 240, 0, 240, 0, 240, 0, 0};
    checks++;
    if (mask_en !== 1'b0 || mask !== 1'b0) begin
      errors++; $display("FAIL reset_mask: mask_en=%b mask=%b, required 0 0", mask_en, mask);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: frame_done=%b, required 0", frame_done);
    end
    checks++;
    if (match_count !== 20'd0) begin
      errors++; $display("FAIL reset_count: match_count=%0d, required 0", match_count);
    end
    checks++;
    if ({bbox_valid, xmin, xmax, ymin, ymax} !== 41'd0) begin
      errors++; $display("FAIL reset_bbox: valid=%b bbox=%0d,%0d,%0d,%0d, required all 0",
                         bbox_valid, xmin, xmax, ymin, ymax);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_default_window();
    for (int i = 0; i < NPIX; i++) begin ph[i] = 100; ps[i] = 100; pl[i] = 100; end
    compute_expected();
    send_frame(0, 0, -1, 0, 0);
    checks++;
    if (got_mask.size() != NPIX) begin
      errors++; $display("FAIL default_mask_len: got %0d masks, required %0d", got_mask.size(), NPIX);
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        checks++;
        if (got_mask[i] !== exp_mask[i]) begin
          errors++; $display("FAIL default_mask[%0d]: got %b, required %b", i, got_mask[i], exp_mask[i]);
        end
      end
    end
    checks++;
    if (done_cnt - done_base != 1 || done_edge != last_edge + 1) begin
      errors++; $display("FAIL default_done: pulses=%0d at edge %0d, required 1 at edge %0d",
                         done_cnt - done_base, done_edge, last_edge + 1);
    end
    checks++;
    if (match_count !== 20'd8) begin
      errors++; $display("FAIL default_count: got %0d, required 8", match_count);
    end
    checks++;
    if ({bbox_valid, xmin, xmax, ymin, ymax} !== {exp_any, exp_bb}) begin
      errors++; $display("FAIL default_bbox: valid=%b x %0d..%0d y %0d..%0d, required %b %h",
                         bbox_valid, xmin, xmax, ymin, ymax, exp_any, exp_bb);
    end
  endtask

  task automatic test_hue_wrap_and_empty();
    cfg_write(0, 230); cfg_write(1, 10);
    ph[0] = 235; ph[1] = 5; ph[2] = 120; ph[3] = 240;
    for (int i = 4; i < NPIX; i++) ph[i] = $urandom_range(0, 240);
    for (int i = 0; i < NPIX; i++) begin ps[i] = 100; pl[i] = 100; end
    compute_expected();
    send_frame(0, 0, -1, 0, 0);
    checks++;
    if (got_mask.size() != NPIX) begin
      errors++; $display("FAIL wrap_mask_len: got %0d masks, required %0d", got_mask.size(), NPIX);
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        checks++;
        if (got_mask[i] !== exp_mask[i]) begin
          errors++; $display("FAIL wrap_mask[%0d] H=%0d: got %b, required %b", i, ph[i], got_mask[i], exp_mask[i]);
        end
      end
    end
    checks++;
    if (match_count !== 20'(exp_cnt)) begin
      errors++; $display("FAIL wrap_count: got %0d, required %0d", match_count, exp_cnt);
    end
    cfg_write(2, 50); cfg_write(3, 40);
    for (int i = 0; i < NPIX; i++) begin
      ph[i] = $urandom_range(0, 240); ps[i] = $urandom_range(0, 240); pl[i] = $urandom_range(0, 240);
    end
    compute_expected();
    send_frame(1, 0, -1, 0, 0);
    checks++;
    if (got_mask.size() != NPIX || got_mask.sum() with (int'(item)) != 0) begin
      errors++; $display("FAIL empty_masks: %0d masks with %0d set, required %0d with 0 set",
                         got_mask.size(), got_mask.sum() with (int'(item)), NPIX);
    end
    checks++;
    if (done_cnt - done_base != 1 || match_count !== 20'd0) begin
      errors++; $display("FAIL empty_result: pulses=%0d count=%0d, required 1 pulse count 0",
                         done_cnt - done_base, match_count);
    end
    checks++;
    if ({bbox_valid, xmin, xmax, ymin, ymax} !== 41'd0) begin
      errors++; $display("FAIL empty_bbox: valid=%b x %0d..%0d y %0d..%0d, required all 0",
                         bbox_valid, xmin, xmax, ymin, ymax);
    end
  endtask

  task automatic test_midframe_cfg();
    cfg_defaults();
    for (int i = 0; i < NPIX; i++) begin
      ph[i] = $urandom_range(120, 240); ps[i] = 100; pl[i] = 100;
    end
    ph[1] = 150; ph[5] = 220;
    compute_expected();
    send_frame(0, 0, 3, 0, 200);
    checks++;
    if (match_count !== 20'(exp_cnt) || got_mask.size() != NPIX) begin
      errors++; $display("FAIL midcfg_same_frame: count=%0d masks=%0d, required %0d and %0d",
                         match_count, got_mask.size(), exp_cnt, NPIX);
    end
    compute_expected();
    send_frame(0, 0, -1, 0, 0);
    checks++;
    if (got_mask.size() != NPIX) begin
      errors++; $display("FAIL midcfg_next_len: got %0d masks, required %0d", got_mask.size(), NPIX);
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        checks++;
        if (got_mask[i] !== exp_mask[i]) begin
          errors++; $display("FAIL midcfg_next_mask[%0d] H=%0d: got %b, required %b", i, ph[i], got_mask[i], exp_mask[i]);
        end
      end
    end
    checks++;
    if (match_count !== 20'(exp_cnt)) begin
      errors++; $display("FAIL midcfg_next_count: got %0d, required %0d", match_count, exp_cnt);
    end
  endtask

  task automatic test_single_match();
    cfg_defaults();
    cfg_write(0, 50); cfg_write(1, 60);
    for (int i = 0; i < NPIX; i++) begin
      ph[i] = 150; ps[i] = $urandom_range(0, 240); pl[i] = $urandom_range(0, 240);
    end
    ph[1 * W + 2] = 55;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) cfg_write(6, 1);
      compute_expected();
      send_frame(1, pass, -1, 0, 0);
      checks++;
      if (match_count !== 20'(exp_cnt) || done_cnt - done_base != 1) begin
        errors++; $display("FAIL single_count inv=%0d: count=%0d pulses=%0d, required %0d and 1",
                           pass, match_count, done_cnt - done_base, exp_cnt);
      end
      checks++;
      if ({bbox_valid, xmin, xmax, ymin, ymax} !== {exp_any, exp_bb}) begin
        errors++; $display("FAIL single_bbox inv=%0d: valid=%b x %0d..%0d y %0d..%0d, required %b %h",
                           pass, bbox_valid, xmin, xmax, ymin, ymax, exp_any, exp_bb);
      end
    end
    cfg_write(6, 0);
  endtask

  task automatic test_abort();
    cfg_defaults();
    idle(2);
    done_base = done_cnt;
    for (int i = 0; i < 5; i++) drive(i == 0, 1, 100, 100, 100, 0, 0, 0);
    idle(4);
    checks++;
    if (done_cnt != done_base) begin
      errors++; $display("FAIL abort_no_done: %0d pulses after partial frame, required 0", done_cnt - done_base);
    end
    cfg_write(4, 90); cfg_write(5, 180);
    sh[4] = 0; sh[5] = 240;
    for (int i = 0; i < NPIX; i++) begin
      ph[i] = $urandom_range(0, 240); ps[i] = $urandom_range(0, 240); pl[i] = $urandom_range(0, 240);
    end
    compute_expected();
    send_frame(0, 0, -1, 0, 0);
    sh[4] = 90; sh[5] = 180;
    checks++;
    if (done_cnt - done_base != 1 || done_edge != last_edge + 1) begin
      errors++; $display("FAIL abort_done: pulses=%0d at edge %0d, required 1 at edge %0d",
                         done_cnt - done_base, done_edge, last_edge + 1);
    end
    checks++;
    if (match_count !== 20'(exp_cnt)) begin
      errors++; $display("FAIL abort_count: got %0d, required %0d", match_count, exp_cnt);
    end
    checks++;
    if ({bbox_valid, xmin, xmax, ymin, ymax} !== {exp_any, exp_bb}) begin
      errors++; $display("FAIL abort_bbox: valid=%b x %0d..%0d y %0d..%0d, required %b %h",
                         bbox_valid, xmin, xmax, ymin, ymax, exp_any, exp_bb);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int bad;
      cfg_write(0, $urandom_range(0, 240)); cfg_write(1, $urandom_range(0, 240));
      cfg_write(2, $urandom_range(0, 120)); cfg_write(3, $urandom_range(100, 240));
      cfg_write(4, $urandom_range(0, 120)); cfg_write(5, $urandom_range(100, 240));
      cfg_write(6, $urandom_range(0, 1));
      for (int i = 0; i < NPIX; i++) begin
        ph[i] = $urandom_range(0, 240); ps[i] = $urandom_range(0, 240); pl[i] = $urandom_range(0, 240);
      end
      compute_expected();
      send_frame(2, 1'($urandom_range(0, 1)), -1, 0, 0);
      bad = 0;
      for (int i = 0; i < NPIX && i < got_mask.size(); i++) if (got_mask[i] !== exp_mask[i]) bad++;
      checks++;
      if (got_mask.size() != NPIX || bad != 0) begin
        errors++; $display("FAIL rand%0d_masks: %0d masks, %0d wrong, required %0d masks 0 wrong",
                           f, got_mask.size(), bad, NPIX);
      end
      checks++;
      if (done_cnt - done_base != 1 || done_edge != last_edge + 1 || match_count !== 20'(exp_cnt)) begin
        errors++; $display("FAIL rand%0d_result: pulses=%0d edge=%0d count=%0d, required 1 edge=%0d count=%0d",
                           f, done_cnt - done_base, done_edge, match_count, last_edge + 1, exp_cnt);
      end
      checks++;
      if ({bbox_valid, xmin, xmax, ymin, ymax} !== {exp_any, exp_bb}) begin
        errors++; $display("FAIL rand%0d_bbox: valid=%b x %0d..%0d y %0d..%0d, required %b %h",
                           f, bbox_valid, xmin, xmax, ymin, ymax, exp_any, exp_bb);
      end
    end
  endtask

  task automatic test_reset_midframe();
    idle(2);
    for (int i = 0; i < 3; i++) drive(i == 0, 1, 100, 100, 100, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({mask_en, mask, frame_done, match_count, bbox_valid, xmin, xmax, ymin, ymax} !== 64'd0) begin
      errors++; $display("FAIL midreset_outputs: en=%b mask=%b done=%b count=%0d bbox=%b, required all 0",
                         mask_en, mask, frame_done, match_count, bbox_valid);
    end
    idle(2);
    rst_n = 1'b1;
    sh = '{0, 240, 0, 240, 0, 240, 0, 0};
    idle(1);
    got_mask.delete();
    for (int i = 0; i < 3; i++) drive(0, 1, 100, 100, 100, 0, 0, 0);
    idle(2);
    checks++;
    if (got_mask.size() != 0) begin
      errors++; $display("FAIL idle_ignored: got %0d mask_en pulses, required 0", got_mask.size());
    end
    for (int i = 0; i < NPIX; i++) begin ph[i] = 100; ps[i] = 100; pl[i] = 100; end
    compute_expected();
    send_frame(0, 0, -1, 0, 0);
    checks++;
    if (match_count !== 20'd8 || done_cnt - done_base != 1) begin
      errors++; $display("FAIL postreset_frame: count=%0d pulses=%0d, required 8 and 1",
                         match_count, done_cnt - done_base);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_window();
    test_hue_wrap_and_empty();
    test_midframe_cfg();
    test_single_match();
    test_abort();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
